// File: rtl/shared_ram_arbiter.sv
// Purpose: round-robin arbiter sharing one 2K x 8 synchronous RAM port between the M68K and the Z80.
// Latency: write 3 cycles, read 3 + RAM_LAT cycles from request seen in IDLE to served; contention adds at most one access.
// Backpressure: M68K is held off by DTACK (high until served), Z80 by WAIT (low from select until served).
module shared_ram_arbiter #(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 8,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m68k_cs,
   input  logic              m68k_rw,
   input  logic              m68k_lds_n,
   input  logic [ADDR_W-1:0] m68k_addr,
   input  logic [DATA_W-1:0] m68k_din,
   output logic [DATA_W-1:0] m68k_dout,
   output logic              m68k_dtack_n,
   input  logic              z80_cs,
   input  logic              z80_rd_n,
   input  logic              z80_wr_n,
   input  logic [ADDR_W-1:0] z80_addr,
   input  logic [DATA_W-1:0] z80_din,
   output logic [DATA_W-1:0] z80_dout,
   output logic              z80_wait_n,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {IDLE, ACC, LAT, DONE} state_t;

   // Count value on the cycle ram_rdata becomes valid for the latched address.
   localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

   state_t     state, state_nxt;
   logic       owner;      // 0 = M68K, 1 = Z80
   logic       last;       // CPU granted most recently, used to break ties
   logic       m_served, z_served;
   logic       acc_we;     // latched direction of the granted access
   logic [1:0] lat_cnt;
   logic       m_req, z_req, m_null, grant, grant_z, capture;

   assign m_req   = m68k_cs & ~m_served & (m68k_rw | ~m68k_lds_n);
   assign z_req   = z80_cs & (~z80_rd_n | ~z80_wr_n) & ~z_served;
   // Upper-byte-only M68K write: nothing for this RAM to do, acknowledge directly.
   assign m_null  = m68k_cs & ~m_served & ~m68k_rw & m68k_lds_n;
   // Z80 takes the grant when alone, or on a tie when the M68K went last.
   assign grant_z = z_req & (~m_req | ~last);

   assign m68k_dtack_n = ~(m_served & m68k_cs);
   assign z80_wait_n   = ~(z80_cs & ~z_served);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state plus per-state strobes (grant, RAM write, read capture)
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      ram_we    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (m_req | z_req) begin
               grant     = 1'b1;
               state_nxt = ACC;
            end
         end
         ACC: begin
            if (acc_we) begin
               ram_we    = 1'b1;
               state_nxt = DONE;
            end else begin
               state_nxt = LAT;
            end
         end
         LAT: begin
            if (lat_cnt == LAT_LAST) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch owner, address, write data and direction at grant; RAM address holds while idle
   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= 1'b0;
         acc_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else if (grant) begin
         owner     <= grant_z;
         acc_we    <= grant_z ? ~z80_wr_n : ~m68k_rw;
         ram_addr  <= grant_z ? z80_addr  : m68k_addr;
         ram_wdata <= grant_z ? z80_din   : m68k_din;
      end
   end

   // RAM read latency counter, running only while in LAT
   always_ff @(posedge clk) begin
      if (reset || state != LAT) lat_cnt <= 2'd0;
      else                       lat_cnt <= lat_cnt + 2'd1;
   end

   // Capture read data into the owning CPU's holding register
   always_ff @(posedge clk) begin
      if (reset) begin
         m68k_dout <= '0;
         z80_dout  <= '0;
      end else if (capture) begin
         if (owner) z80_dout  <= ram_rdata;
         else       m68k_dout <= ram_rdata;
      end
   end

   // Served flags (one access per bus cycle) and round-robin history
   always_ff @(posedge clk) begin
      if (reset) begin
         m_served <= 1'b0;
         z_served <= 1'b0;
         last     <= 1'b1;
      end else begin
         if (state == DONE) last <= owner;
         // Completion wins over the cs-low clear so an abandoned access still
         // reports served for one cycle, then clears.
         if ((state == DONE && !owner) || (state == IDLE && m_null)) m_served <= 1'b1;
         else if (!m68k_cs)                                          m_served <= 1'b0;
         if (state == DONE && owner) z_served <= 1'b1;
         else if (!z80_cs)           z_served <= 1'b0;
      end
   end

endmodule
